piso_serializer8: RTL

- Parallel-in/serial-out stage that directly drives the 8:1 bit-select mux.
- Captures an 8-bit word, then steps a 3-bit select counter through all eight positions, one accepted bit per cycle.
- Emits the selected bit downstream over a valid/ready handshake.
- Sits between a byte-wide producer (upstream) and a bit-serial consumer (line driver, CRC, shift-out pin logic).

---
 rtl/piso_serializer8_pkg.sv | 23 ++
 rtl/piso_serializer8_mux81.sv | 30 +++
 rtl/piso_serializer8.sv | 98 +++++++++
 3 files changed

// File: rtl/piso_serializer8_pkg.sv
// Shared types and index helpers for the 8-bit parallel-in/serial-out stage.
package piso_pkg;

   localparam int SEL_W  = 3;
   localparam int WORD_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // First mux position visited for a word.
   function automatic logic [SEL_W-1:0] start_idx(input bit lsb_first);
      return lsb_first ? SEL_W'(0) : SEL_W'(WORD_W - 1);
   endfunction

   // Last mux position visited for a word.
   function automatic logic [SEL_W-1:0] end_idx(input bit lsb_first);
      return lsb_first ? SEL_W'(WORD_W - 1) : SEL_W'(0);
   endfunction

endpackage

// File: rtl/piso_serializer8_mux81.sv
// Behavioural 8:1 single-bit mux; y follows input i<s>.
module mux81_bh (
   input  logic       i0,
   input  logic       i1,
   input  logic       i2,
   input  logic       i3,
   input  logic       i4,
   input  logic       i5,
   input  logic       i6,
   input  logic       i7,
   input  logic [2:0] s,
   output logic       y
);

   always_comb begin
      y = i0;
      case (s)
         3'd0: y = i0;
         3'd1: y = i1;
         3'd2: y = i2;
         3'd3: y = i3;
         3'd4: y = i4;
         3'd5: y = i5;
         3'd6: y = i6;
         3'd7: y = i7;
         default: y = i0;
      endcase
   end

endmodule

// File: rtl/piso_serializer8.sv
// Byte-to-bit serializer: captures a word, walks the mux select across it
// under a valid/ready handshake, with optional idle gap between words.
module piso_serializer8
   import piso_pkg::*;
#(
   parameter bit          LSB_FIRST = 1'b1,
   parameter int unsigned IDLE_GAP  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [WORD_W-1:0] load_data,
   output logic              ser_out,
   output logic              ser_valid,
   input  logic              ser_ready,
   output logic              ser_last,
   output logic [SEL_W-1:0]  sel,
   output logic              busy
);

   localparam logic [SEL_W-1:0] START_SEL = start_idx(LSB_FIRST);
   localparam logic [SEL_W-1:0] END_SEL   = end_idx(LSB_FIRST);
   localparam bit               NO_GAP    = (IDLE_GAP == 0);
   localparam logic [3:0]       GAP_LOAD  = NO_GAP ? 4'd0 : 4'(IDLE_GAP - 1);

   state_t             state;
   logic [WORD_W-1:0]  hold;
   logic [SEL_W-1:0]   sel_q;
   logic [3:0]         gap_cnt;
   logic               at_end;
   logic               load_fire;

   // All handshake outputs decode registered state/sel only, except the
   // ready->ready path that lets a new word land on the last bit's cycle.
   assign at_end     = (sel_q == END_SEL);
   assign ser_valid  = (state == SHIFT);
   assign ser_last   = ser_valid & at_end;
   assign busy       = (state != IDLE);
   assign sel        = sel_q;
   assign load_ready = (state == IDLE) | (ser_last & ser_ready & NO_GAP);
   assign load_fire  = load_valid & load_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         hold    <= '0;
         sel_q   <= START_SEL;
         gap_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_fire) begin
                  hold  <= load_data;
                  sel_q <= START_SEL;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (ser_ready) begin
                  if (!at_end) begin
                     sel_q <= LSB_FIRST ? sel_q + 3'd1 : sel_q - 3'd1;
                  end else if (NO_GAP) begin
                     if (load_valid) begin
                        hold  <= load_data;
                        sel_q <= START_SEL;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     state   <= GAP;
                     gap_cnt <= GAP_LOAD;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == 4'd0) state <= IDLE;
               else                 gap_cnt <= gap_cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   mux81_bh u_mux (
      .i0 (hold[0]),
      .i1 (hold[1]),
      .i2 (hold[2]),
      .i3 (hold[3]),
      .i4 (hold[4]),
      .i5 (hold[5]),
      .i6 (hold[6]),
      .i7 (hold[7]),
      .s  (sel_q),
      .y  (ser_out)
   );

endmodule
